// File: rtl/counter_core_if.sv
// Control and status bundle for counter_core: the driver side uses master, the counter uses slave.
interface counter_core_if #(
   parameter int WIDTH = 4
);
   logic             load;
   logic [WIDTH-1:0] data_in;
   logic             enable;
   logic             up_down;
   logic [WIDTH-1:0] count;
   logic             tc_up;
   logic             tc_down;
   logic             wrap;

   modport master (output load, data_in, enable, up_down,
                   input  count, tc_up, tc_down, wrap);
   modport slave  (input  load, data_in, enable, up_down,
                   output count, tc_up, tc_down, wrap);
endinterface

// File: rtl/counter_core.sv
// Loadable up/down modulo counter with registered terminal-count flags and wrap pulse.
// Define COUNTER_SATURATE_EN to saturate at 0 / MAX_VAL instead of wrapping.
module counter_core #(
   parameter int WIDTH   = 4,
   parameter int MAX_VAL = 2**WIDTH-1
) (
   input logic           clk,
   input logic           rst,
   counter_core_if.slave bus
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             wrap_q, wrap_d;
   logic             tcu_q, tcd_q;

   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (bus.load) begin
         cnt_d = (bus.data_in > MAX) ? MAX : bus.data_in;
      end else if (bus.enable) begin
         if (bus.up_down) begin
            if (cnt_q >= MAX) begin
`ifdef COUNTER_SATURATE_EN
               cnt_d  = MAX;
`else
               cnt_d  = '0;
               wrap_d = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            if (cnt_q == '0) begin
`ifdef COUNTER_SATURATE_EN
               cnt_d  = '0;
`else
               cnt_d  = MAX;
               wrap_d = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      end
   end

   // Flags are derived from the next count so they line up with the registered value.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         wrap_q <= 1'b0;
         tcu_q  <= (MAX == '0);
         tcd_q  <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
         tcu_q  <= (cnt_d == MAX);
         tcd_q  <= (cnt_d == '0);
      end
   end

   assign bus.count   = cnt_q;
   assign bus.wrap    = wrap_q;
   assign bus.tc_up   = tcu_q;
   assign bus.tc_down = tcd_q;
endmodule

// File: tb/tb_counter_core.sv
// Scoreboard bench for counter_core: a full-range 4-bit instance and a MAX_VAL=9 instance.
module tb_counter_core;
   typedef struct packed {
      logic [3:0] count;
      logic       tc_up;
      logic       tc_down;
      logic       wrap;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   counter_core_if #(.WIDTH(4)) bus_a ();
   counter_core_if #(.WIDTH(4)) bus_b ();

   counter_core #(.WIDTH(4))              dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   counter_core #(.WIDTH(4), .MAX_VAL(9)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   function automatic exp_t mk(input int c, input bit w, input int m);
      exp_t e;
      e.count   = 4'(c);
      e.tc_up   = (c == m);
      e.tc_down = (c == 0);
      e.wrap    = w;
      return e;
   endfunction

   task automatic drive(input bit r, input bit ld, input int d, input bit en, input bit ud);
      rst           = r;
      bus_a.load    = ld;
      bus_a.data_in = 4'(d);
      bus_a.enable  = en;
      bus_a.up_down = ud;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         drive(i < 2, 1'b0, 0, 1'b1, 1'b1);
         exp_q.push_back(mk(i < 2 ? 0 : 1, 1'b0, 15));
         cyc();
         e = exp_q.pop_front();
         n_cmp++;
         if ({bus_a.count, bus_a.tc_up, bus_a.tc_down, bus_a.wrap} !== e) begin
            n_bad++;
            $display("FAIL reset[%0d]: got count=%0d tcu=%b tcd=%b wrap=%b, want count=%0d tcu=%b tcd=%b wrap=%b",
                     i, bus_a.count, bus_a.tc_up, bus_a.tc_down, bus_a.wrap, e.count, e.tc_up, e.tc_down, e.wrap);
         end
      end
   endtask

   task automatic test_up_wrap();
      exp_t e;
      int ec[5];
      bit ew[5];
`ifdef COUNTER_SATURATE_EN
      ec = '{13, 14, 15, 15, 15}; ew = '{0, 0, 0, 0, 0};
`else
      ec = '{13, 14, 15, 0, 1};   ew = '{0, 0, 0, 1, 0};
`endif
      for (int i = 0; i < 5; i++) begin
         if (i == 0) drive(1'b0, 1'b1, 13, 1'b0, 1'b0);
         else        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
         exp_q.push_back(mk(ec[i], ew[i], 15));
         cyc();
         e = exp_q.pop_front();
         n_cmp++;
         if ({bus_a.count, bus_a.tc_up, bus_a.tc_down, bus_a.wrap} !== e) begin
            n_bad++;
            $display("FAIL up_wrap[%0d]: got count=%0d tcu=%b tcd=%b wrap=%b, want count=%0d tcu=%b tcd=%b wrap=%b",
                     i, bus_a.count, bus_a.tc_up, bus_a.tc_down, bus_a.wrap, e.count, e.tc_up, e.tc_down, e.wrap);
         end
      end
   endtask

   task automatic test_down_wrap();
      exp_t e;
      int ec[4];
      bit ew[4];
`ifdef COUNTER_SATURATE_EN
      ec = '{1, 0, 0, 0};   ew = '{0, 0, 0, 0};
`else
      ec = '{1, 0, 15, 14}; ew = '{0, 0, 1, 0};
`endif
      for (int i = 0; i < 4; i++) begin
         if (i == 0) drive(1'b0, 1'b1, 1, 1'b0, 1'b1);
         else        drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
         exp_q.push_back(mk(ec[i], ew[i], 15));
         cyc();
         e = exp_q.pop_front();
         n_cmp++;
         if ({bus_a.count, bus_a.tc_up, bus_a.tc_down, bus_a.wrap} !== e) begin
            n_bad++;
            $display("FAIL down_wrap[%0d]: got count=%0d tcu=%b tcd=%b wrap=%b, want count=%0d tcu=%b tcd=%b wrap=%b",
                     i, bus_a.count, bus_a.tc_up, bus_a.tc_down, bus_a.wrap, e.count, e.tc_up, e.tc_down, e.wrap);
         end
      end
   endtask

   task automatic test_priority();
      exp_t e;
      int ec[4];
      ec = '{3, 9, 0, 0};
      for (int i = 0; i < 4; i++) begin
         case (i)
            0:       drive(1'b0, 1'b1, 3, 1'b0, 1'b0);
            1:       drive(1'b0, 1'b1, 9, 1'b1, 1'b1);
            2:       drive(1'b1, 1'b1, 5, 1'b1, 1'b1);
            default: drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
         endcase
         exp_q.push_back(mk(ec[i], 1'b0, 15));
         cyc();
         e = exp_q.pop_front();
         n_cmp++;
         if ({bus_a.count, bus_a.tc_up, bus_a.tc_down, bus_a.wrap} !== e) begin
            n_bad++;
            $display("FAIL priority[%0d]: got count=%0d tcu=%b tcd=%b wrap=%b, want count=%0d tcu=%b tcd=%b wrap=%b",
                     i, bus_a.count, bus_a.tc_up, bus_a.tc_down, bus_a.wrap, e.count, e.tc_up, e.tc_down, e.wrap);
         end
      end
   endtask

   task automatic test_hold_dir();
      exp_t e;
      int ec[10];
      ec = '{7, 7, 7, 7, 7, 7, 8, 7, 8, 7};
      for (int i = 0; i < 10; i++) begin
         if (i == 0)     drive(1'b0, 1'b1, 7, 1'b0, 1'b0);
         else if (i < 6) drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
         else            drive(1'b0, 1'b0, 0, 1'b1, (i % 2) == 0);
         exp_q.push_back(mk(ec[i], 1'b0, 15));
         cyc();
         e = exp_q.pop_front();
         n_cmp++;
         if ({bus_a.count, bus_a.tc_up, bus_a.tc_down, bus_a.wrap} !== e) begin
            n_bad++;
            $display("FAIL hold_dir[%0d]: got count=%0d tcu=%b tcd=%b wrap=%b, want count=%0d tcu=%b tcd=%b wrap=%b",
                     i, bus_a.count, bus_a.tc_up, bus_a.tc_down, bus_a.wrap, e.count, e.tc_up, e.tc_down, e.wrap);
         end
      end
   endtask

   // Alternating up-at-max and down-at-zero wraps on consecutive edges keep wrap high.
   task automatic test_back_to_back();
      exp_t e;
      int ec[5];
      bit ew[5];
`ifdef COUNTER_SATURATE_EN
      ec = '{15, 15, 14, 15, 15}; ew = '{0, 0, 0, 0, 0};
`else
      ec = '{15, 0, 15, 0, 0};    ew = '{0, 1, 1, 1, 0};
`endif
      for (int i = 0; i < 5; i++) begin
         if (i == 0)      drive(1'b0, 1'b1, 15, 1'b0, 1'b0);
         else if (i == 4) drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
         else             drive(1'b0, 1'b0, 0, 1'b1, (i % 2) == 1);
         exp_q.push_back(mk(ec[i], ew[i], 15));
         cyc();
         e = exp_q.pop_front();
         n_cmp++;
         if ({bus_a.count, bus_a.tc_up, bus_a.tc_down, bus_a.wrap} !== e) begin
            n_bad++;
            $display("FAIL back_to_back[%0d]: got count=%0d tcu=%b tcd=%b wrap=%b, want count=%0d tcu=%b tcd=%b wrap=%b",
                     i, bus_a.count, bus_a.tc_up, bus_a.tc_down, bus_a.wrap, e.count, e.tc_up, e.tc_down, e.wrap);
         end
      end
   endtask

   task automatic test_modulus();
      exp_t e;
      int ec[4];
      bit ew[4];
`ifdef COUNTER_SATURATE_EN
      ec = '{9, 9, 9, 8}; ew = '{0, 0, 0, 0};
`else
      ec = '{9, 0, 0, 9}; ew = '{0, 1, 0, 1};
`endif
      drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         bus_b.load    = (i == 0);
         bus_b.data_in = 4'd12;
         bus_b.enable  = (i != 2);
         bus_b.up_down = (i == 1);
         exp_q.push_back(mk(ec[i], ew[i], 9));
         cyc();
         e = exp_q.pop_front();
         n_cmp++;
         if ({bus_b.count, bus_b.tc_up, bus_b.tc_down, bus_b.wrap} !== e) begin
            n_bad++;
            $display("FAIL modulus[%0d]: got count=%0d tcu=%b tcd=%b wrap=%b, want count=%0d tcu=%b tcd=%b wrap=%b",
                     i, bus_b.count, bus_b.tc_up, bus_b.tc_down, bus_b.wrap, e.count, e.tc_up, e.tc_down, e.wrap);
         end
      end
      bus_b.load   = 1'b0;
      bus_b.enable = 1'b0;
   endtask

   task automatic test_random();
      exp_t e;
      int   mc = 0;
      bit   mw;
      bit   r, ld, en, ud;
      int   d;
      for (int i = 0; i < 300; i++) begin
         r  = (i == 0) || ($urandom_range(31) == 0);
         ld = ($urandom_range(7) == 0);
         en = ($urandom_range(3) != 0);
         ud = $urandom_range(1);
         d  = $urandom_range(15);
         drive(r, ld, d, en, ud);
         mw = 1'b0;
         if (r) mc = 0;
         else if (ld) mc = d;
         else if (en) begin
`ifdef COUNTER_SATURATE_EN
            mc = ud ? ((mc == 15) ? 15 : mc + 1) : ((mc == 0) ? 0 : mc - 1);
`else
            mw = ud ? (mc == 15) : (mc == 0);
            mc = ud ? (mc + 1) % 16 : (mc + 15) % 16;
`endif
         end
         exp_q.push_back(mk(mc, mw, 15));
         cyc();
         e = exp_q.pop_front();
         n_cmp++;
         if ({bus_a.count, bus_a.tc_up, bus_a.tc_down, bus_a.wrap} !== e) begin
            n_bad++;
            $display("FAIL random[%0d]: got count=%0d tcu=%b tcd=%b wrap=%b, want count=%0d tcu=%b tcd=%b wrap=%b",
                     i, bus_a.count, bus_a.tc_up, bus_a.tc_down, bus_a.wrap, e.count, e.tc_up, e.tc_down, e.wrap);
         end
      end
   endtask

   initial begin
      bus_b.load    = 1'b0;
      bus_b.data_in = '0;
      bus_b.enable  = 1'b0;
      bus_b.up_down = 1'b0;
      drive(1'b1, 1'b0, 0, 1'b1, 1'b1);
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_priority();
      test_hold_dir();
      test_back_to_back();
      test_modulus();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/counter_core.md
Name: counter_core

Overview:
- Synchronous loadable up/down counter, default 4-bit, with programmable modulus and terminal-count flags.
- Driven by the counter testbench interface: clock, reset, control inputs in; count value and status flags out.
- Serves as the DUT for random and directed count/load/direction tests.
- All outputs are registered; no combinational input-to-output paths.

Parameters:
- WIDTH, 4: counter width in bits.
- MAX_VAL, 2**WIDTH-1: highest count value; counting wraps between 0 and MAX_VAL. Legal range is 1..2**WIDTH-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- load  in  1  when high, load data_in on the next edge.
- data_in  in  WIDTH  load value. Values above MAX_VAL are clamped to MAX_VAL.
- enable  in  1  count enable.
- up_down  in  1  direction: 1 = up, 0 = down.
- count  out  WIDTH  current count, registered.
- tc_up  out  1  registered; high while count == MAX_VAL.
- tc_down  out  1  registered; high while count == 0.
- wrap  out  1  one-cycle pulse, asserted the cycle after a wrap occurred.

Behaviour:
- All state updates happen on the rising edge of clk.
- Priority per edge: rst > load > enable > hold.
- rst high at an edge: count=0, wrap=0, tc_down=1, tc_up=(MAX_VAL==0 ? 1 : 0), which is 0 for any legal MAX_VAL.
- Reset asserted mid-count or during a load overrides everything on that edge.
- load=1 (rst=0): count <= min(data_in, MAX_VAL). Direction and enable are ignored that cycle. wrap <= 0.
- enable=1, load=0, up_down=1:
  - count < MAX_VAL: count+1.
  - count == MAX_VAL: count <= 0 and wrap <= 1.
- enable=1, load=0, up_down=0:
  - count > 0: count-1.
  - count == 0: count <= MAX_VAL and wrap <= 1.
- enable=0, load=0: count holds, wrap <= 0.
- wrap is high for exactly one cycle per wrap event. On consecutive wraps (e.g. MAX_VAL=1) it stays high continuously.
- tc_up and tc_down are registered alongside count and always reflect the new count value, never the previous one.
- Latency: control inputs at edge N are reflected in count after edge N, i.e. one cycle.
- A direction change takes effect on the same edge it is sampled.
- Inputs are assumed synchronous to clk; the block contains no synchronizers.
- Arithmetic is unsigned modulo (MAX_VAL+1). No X propagation out of reset.

Optional Feature:
- Macro COUNTER_SATURATE_EN.
- Defined: counting saturates instead of wrapping.
  - Up at MAX_VAL holds MAX_VAL; down at 0 holds 0.
  - wrap is never asserted (tied 0).
  - tc_up/tc_down behave as above.
- Undefined: wrap-around behaviour as specified in Behaviour.
- Load and reset behaviour are identical in both builds.

Test Plan:
- Reset: rst=1 for 2 cycles with enable=1, up_down=1 -> count=0, tc_down=1, tc_up=0, wrap=0. After release, count=1 one cycle later.
- Up wrap, WIDTH=4: load 4'd13, then enable up for 4 cycles -> 14, 15 (tc_up=1), 0 (wrap=1 for one cycle, tc_down=1), 1.
- Down wrap: load 4'd1, enable down for 3 cycles -> 0 (tc_down=1), 15 (wrap=1), 14.
- Priority: load=1, enable=1, up_down=1, data_in=9 at count 3 -> count=9, not 4. Next, rst=1 and load=1 together -> count=0.
- Hold and direction: enable=0 for 5 cycles at count 7 -> stays 7. Then toggle up_down each cycle with enable=1 -> 8, 7, 8, 7.
- Modulus/saturate: MAX_VAL=9, load 12 -> count=9; up -> 0 with wrap=1. Same stimulus with COUNTER_SATURATE_EN -> count stays 9, wrap=0.
